// File: rtl/timer_pkg.sv
// Shared types for the interval timer.
//   state_t        : controller state (IDLE / RUN / PAUSE)
//   MODE_PERIODIC  : reload on expiry and keep running
//   MODE_ONESHOT   : return to IDLE on expiry
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   localparam logic MODE_PERIODIC = 1'b0;
   localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/interval_timer_if.sv
// Control/status bundle between the game FSM (master) and the timer (slave).
//   start, stop     : single-cycle requests from the master
//   enable          : level, low pauses counting
//   mode, period    : configuration, sampled together with start
//   timeout_pulse   : one-cycle expiry pulse from the timer
//   busy, remaining : timer status
interface interval_timer_if #(
   parameter int CNT_W = 8
);
   logic             start;
   logic             stop;
   logic             enable;
   logic             mode;
   logic [CNT_W-1:0] period;
   logic             timeout_pulse;
   logic             busy;
   logic [CNT_W-1:0] remaining;

   modport master (
      output start, stop, enable, mode, period,
      input  timeout_pulse, busy, remaining
   );

   modport slave (
      input  start, stop, enable, mode, period,
      output timeout_pulse, busy, remaining
   );
endinterface

// File: rtl/interval_timer_tick_prescaler.sv
// Base-tick prescaler: divides clk by TICK_DIV while run is high.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : return the count to 0 (has priority over run)
//   run      : count this cycle; low holds the count
//   tick     : combinational, high in the last cycle of each tick period
module tick_prescaler #(
   parameter int TICK_DIV = 5_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic tick
);

   localparam int            CW   = $clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      tick  = run && (cnt_q == LAST);
      cnt_d = cnt_q;
      if (clear || tick) begin
         cnt_d = '0;
      end else if (run) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/interval_timer.sv
// Programmable interval timer with periodic / one-shot modes, pause via
// enable, stop and restart, and a readable remaining tick count.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : interval_timer_if slave port (start/stop/enable/mode/period in,
//              timeout_pulse/busy/remaining out, all outputs registered)
module interval_timer
   import timer_pkg::*;
#(
   parameter int TICK_DIV = 5_000_000,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   interval_timer_if.slave  bus
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             mode_q, mode_d;
   logic             pulse_q, pulse_d;
   logic             busy_q, busy_d;
   logic             tick;
   logic             presc_run;
   logic             presc_clear;

   // The prescaler counts in every busy cycle with enable high, including the
   // cycle that leaves PAUSE, so a pause costs exactly its own length.
   assign presc_run   = (state_q != IDLE) && bus.enable;
   assign presc_clear = bus.start || bus.stop;

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_presc (
      .clk   (clk),
      .rst   (rst),
      .clear (presc_clear),
      .run   (presc_run),
      .tick  (tick)
   );

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      period_d    = period_q;
      mode_d      = mode_q;
      pulse_d     = 1'b0;

      if (bus.stop) begin
         state_d     = IDLE;
         remaining_d = '0;
      end else if (bus.start) begin
         if (bus.period == '0) begin
            // Zero period: ignored from IDLE, acts as stop while busy.
            state_d     = IDLE;
            remaining_d = '0;
         end else begin
            period_d    = bus.period;
            mode_d      = bus.mode;
            remaining_d = bus.period;
            state_d     = bus.enable ? RUN : PAUSE;
         end
      end else if (state_q != IDLE) begin
         if (tick) begin
            if (remaining_q <= CNT_W'(1)) begin
               pulse_d = 1'b1;
               if (mode_q == MODE_ONESHOT) begin
                  remaining_d = '0;
                  state_d     = IDLE;
               end else begin
                  remaining_d = period_q;
               end
            end else begin
               remaining_d = remaining_q - 1'b1;
            end
         end
         if (state_d != IDLE) begin
            state_d = bus.enable ? RUN : PAUSE;
         end
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         period_q    <= '0;
         mode_q      <= MODE_PERIODIC;
         pulse_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         period_q    <= period_d;
         mode_q      <= mode_d;
         pulse_q     <= pulse_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.timeout_pulse = pulse_q;
   assign bus.busy          = busy_q;
   assign bus.remaining     = remaining_q;

endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer with an abstract cycle-budget model:
// the model tracks how many enabled clock cycles remain until expiry and
// derives the remaining tick count as ceil(cycles_left / TICK_DIV).
module tb_interval_timer;

   localparam int TD = 4;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   interval_timer_if #(.CNT_W(CW)) tif();

   interval_timer #(
      .TICK_DIV (TD),
      .CNT_W    (CW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (tif.slave)
   );

   always #5 clk = ~clk;

   int vecs = 0;
   int errs = 0;

   task automatic check(input string name, input int act, input int exp);
      vecs++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit m_busy   = 0;
   bit m_mode   = 0;
   bit m_pulse  = 0;
   int m_period = 0;
   int m_cl     = 0;

   function automatic int m_rem();
      return m_busy ? (m_cl + TD - 1) / TD : 0;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy = 0; m_mode = 0; m_pulse = 0; m_period = 0; m_cl = 0;
      end else begin
         m_pulse = 0;
         if (tif.stop) begin
            m_busy = 0; m_cl = 0;
         end else if (tif.start) begin
            if (tif.period == 0) begin
               m_busy = 0; m_cl = 0;
            end else begin
               m_busy   = 1;
               m_period = int'(tif.period);
               m_mode   = tif.mode;
               m_cl     = m_period * TD;
            end
         end else if (m_busy && tif.enable) begin
            m_cl--;
            if (m_cl == 0) begin
               m_pulse = 1;
               if (m_mode) m_busy = 0;
               else        m_cl = m_period * TD;
            end
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      check("cmp_pulse", int'(tif.timeout_pulse), int'(m_pulse));
      check("cmp_busy", int'(tif.busy), int'(m_busy));
      check("cmp_remaining", int'(tif.remaining), m_rem());
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_tmr(input int p, input bit m);
      tif.start  = 1'b1;
      tif.period = CW'(p);
      tif.mode   = m;
      step();
      tif.start  = 1'b0;
      tif.period = '1;
      tif.mode   = ~m;
   endtask

   task automatic stop_tmr();
      tif.stop = 1'b1;
      step();
      tif.stop = 1'b0;
   endtask

   initial begin
      tif.start  = 1'b0;
      tif.stop   = 1'b0;
      tif.enable = 1'b1;
      tif.mode   = 1'b0;
      tif.period = '0;

      #2;
      check("reset_pulse", int'(tif.timeout_pulse), 0);
      check("reset_busy", int'(tif.busy), 0);
      check("reset_remaining", int'(tif.remaining), 0);
      #10 rst = 1'b0;
      step();

      // 1: periodic, period 3
      start_tmr(3, 1'b0);
      check("t1_rem_start", int'(tif.remaining), 3);
      check("t1_model_rem_start", m_rem(), 3);
      check("t1_busy_start", int'(tif.busy), 1);
      for (int n = 1; n <= 36; n++) begin
         step();
         check("t1_pulse", int'(tif.timeout_pulse), (n % 12 == 0) ? 1 : 0);
         check("t1_busy", int'(tif.busy), 1);
         if (n == 4)  check("t1_rem4", int'(tif.remaining), 2);
         if (n == 8)  check("t1_rem8", int'(tif.remaining), 1);
         if (n == 12) check("t1_rem12", int'(tif.remaining), 3);
         if (n == 12) check("t1_model_pulse12", int'(m_pulse), 1);
      end
      stop_tmr();
      check("t1_stop_busy", int'(tif.busy), 0);
      check("t1_stop_rem", int'(tif.remaining), 0);

      // 2: one-shot, period 2
      start_tmr(2, 1'b1);
      for (int n = 1; n <= 48; n++) begin
         step();
         check("t2_pulse", int'(tif.timeout_pulse), (n == 8) ? 1 : 0);
         if (n >= 8) begin
            check("t2_busy", int'(tif.busy), 0);
            check("t2_rem", int'(tif.remaining), 0);
         end
      end

      // 3: pause for 5 cycles starting at edge 3
      start_tmr(2, 1'b0);
      for (int n = 1; n <= 16; n++) begin
         tif.enable = (n >= 4 && n <= 8) ? 1'b0 : 1'b1;
         step();
         check("t3_pulse", int'(tif.timeout_pulse), (n == 13) ? 1 : 0);
         check("t3_rem", int'(tif.remaining), (n <= 8 || n >= 13) ? 2 : 1);
      end
      tif.enable = 1'b1;
      stop_tmr();

      // start while enable low goes straight to PAUSE with a loaded count
      tif.enable = 1'b0;
      start_tmr(3, 1'b0);
      repeat (5) step();
      check("t3b_busy", int'(tif.busy), 1);
      check("t3b_rem", int'(tif.remaining), 3);
      tif.enable = 1'b1;
      stop_tmr();

      // 4a: stop and start together
      tif.start = 1'b1; tif.stop = 1'b1; tif.period = 4'd3;
      step();
      tif.start = 1'b0; tif.stop = 1'b0;
      check("t4a_idle_busy", int'(tif.busy), 0);
      start_tmr(3, 1'b0);
      repeat (2) step();
      tif.start = 1'b1; tif.stop = 1'b1; tif.period = 4'd3;
      step();
      tif.start = 1'b0; tif.stop = 1'b0;
      check("t4a_run_busy", int'(tif.busy), 0);
      check("t4a_run_rem", int'(tif.remaining), 0);

      // 4b: restart on the expiry edge of a period-1 timer
      start_tmr(1, 1'b0);
      for (int n = 1; n <= 30; n++) begin
         if (n == 8) begin
            tif.start = 1'b1; tif.period = 4'd5; tif.mode = 1'b0;
         end
         step();
         tif.start = 1'b0;
         check("t4b_pulse", int'(tif.timeout_pulse), (n == 4 || n == 28) ? 1 : 0);
         if (n == 8) check("t4b_rem8", int'(tif.remaining), 5);
      end
      stop_tmr();

      // 5: zero period
      start_tmr(0, 1'b0);
      check("t5_idle_busy", int'(tif.busy), 0);
      check("t5_idle_rem", int'(tif.remaining), 0);
      start_tmr(3, 1'b0);
      repeat (2) step();
      start_tmr(0, 1'b0);
      check("t5_run_busy", int'(tif.busy), 0);
      check("t5_run_rem", int'(tif.remaining), 0);

      // 6: asynchronous reset mid-count
      start_tmr(3, 1'b0);
      repeat (5) step();
      check("t6_rem_before", int'(tif.remaining), 2);
      #1 rst = 1'b1;
      #1;
      check("t6_pulse", int'(tif.timeout_pulse), 0);
      check("t6_busy", int'(tif.busy), 0);
      check("t6_rem", int'(tif.remaining), 0);
      #1 rst = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         step();
         check("t6_post_pulse", int'(tif.timeout_pulse), 0);
         check("t6_post_busy", int'(tif.busy), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
